// File: rtl/pll_sequencer_if.sv
// Phase-step request bus between a requester (master) and pll_sequencer (slave).
interface pll_sequencer_if;
  logic       ps_req;
  logic [2:0] ps_ch;
  logic       ps_up;
  logic [3:0] ps_steps;
  logic       ps_ack;
  logic       ps_err;

  modport master (
    output ps_req,
    output ps_ch,
    output ps_up,
    output ps_steps,
    input  ps_ack,
    input  ps_err
  );

  modport slave (
    input  ps_req,
    input  ps_ch,
    input  ps_up,
    input  ps_steps,
    output ps_ack,
    output ps_err
  );
endinterface

// File: rtl/pll_sequencer.sv
// PLL reset/lock sequencer with lock-loss recovery and optional dynamic phase stepping.
// Phase stepping is compiled in only when PLL_SEQ_PHASE_SHIFT_EN is defined.
module pll_sequencer #(
  parameter int RESET_PULSE_CYCLES  = 16,
  parameter int LOCK_STABLE_CYCLES  = 1024,
  parameter int LOCK_TIMEOUT_CYCLES = 65536,
  parameter int PS_PULSE_CYCLES     = 4,
  parameter int PS_SETTLE_CYCLES    = 8
) (
  input  logic           clk,
  input  logic           rst,
  input  logic           i_pll_lock,
  output logic           o_pll_reset,
  output logic [2:0]     o_ps_sel,
  output logic           o_ps_dir,
  output logic           o_ps_pulse,
  output logic           o_ready,
  output logic           o_mem_rst,
  output logic [7:0]     o_relock_cnt,
  pll_sequencer_if.slave ps_bus
);

  localparam int RW     = $clog2(RESET_PULSE_CYCLES) + 1;
  localparam int SW     = $clog2(LOCK_STABLE_CYCLES) + 1;
  localparam int TW     = $clog2(LOCK_TIMEOUT_CYCLES) + 1;
  localparam int PS_MAX = (PS_PULSE_CYCLES > PS_SETTLE_CYCLES) ? PS_PULSE_CYCLES : PS_SETTLE_CYCLES;
  localparam int PW     = $clog2(PS_MAX) + 1;

  localparam logic [RW-1:0] RST_LAST = RW'(RESET_PULSE_CYCLES - 1);
  localparam logic [SW-1:0] STB_LAST = SW'(LOCK_STABLE_CYCLES - 1);
  localparam logic [TW-1:0] TMO_LAST = TW'(LOCK_TIMEOUT_CYCLES - 1);
  localparam logic [PW-1:0] PUL_LAST = PW'(PS_PULSE_CYCLES - 1);
  localparam logic [PW-1:0] SET_LAST = PW'(PS_SETTLE_CYCLES - 1);

`ifdef PLL_SEQ_PHASE_SHIFT_EN
  typedef enum logic [2:0] {
    RST_PLL   = 3'd0,
    WAIT_LOCK = 3'd1,
    STABLE    = 3'd2,
    READY     = 3'd3,
    PS_PULSE  = 3'd4,
    PS_SETTLE = 3'd5
  } state_t;
`else
  typedef enum logic [1:0] {
    RST_PLL   = 2'd0,
    WAIT_LOCK = 2'd1,
    STABLE    = 2'd2,
    READY     = 2'd3
  } state_t;
`endif

  state_t        r_state;
  logic          r_lock_meta;
  logic          r_lock_sync;
  logic [RW-1:0] r_rst_cnt;
  logic [SW-1:0] r_stb_cnt;
  logic [TW-1:0] r_tmo_cnt;
  logic          r_pll_reset;
  logic          r_ready;
  logic          r_mem_rst;
  logic          r_ps_ack;
  logic          r_ps_err;
  logic [7:0]    r_relock_cnt;
  logic          w_lock;

`ifdef PLL_SEQ_PHASE_SHIFT_EN
  logic [PW-1:0] r_ps_cnt;
  logic [3:0]    r_steps;
  logic [2:0]    r_ps_sel;
  logic          r_ps_dir;
  logic          r_ps_pulse;
`endif

  function automatic logic [7:0] sat_inc8(input logic [7:0] v);
    sat_inc8 = (v == 8'hFF) ? v : (v + 8'd1);
  endfunction

  assign w_lock = r_lock_sync;

  // Two-flop synchronizer for the asynchronous PLL lock indication
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_lock_meta <= 1'b0;
      r_lock_sync <= 1'b0;
    end else begin
      r_lock_meta <= i_pll_lock;
      r_lock_sync <= r_lock_meta;
    end
  end

  // Sequencer FSM with all outputs registered
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state      <= RST_PLL;
      r_rst_cnt    <= '0;
      r_stb_cnt    <= '0;
      r_tmo_cnt    <= '0;
      r_pll_reset  <= 1'b1;
      r_ready      <= 1'b0;
      r_mem_rst    <= 1'b1;
      r_ps_ack     <= 1'b0;
      r_ps_err     <= 1'b0;
      r_relock_cnt <= 8'd0;
`ifdef PLL_SEQ_PHASE_SHIFT_EN
      r_ps_cnt     <= '0;
      r_steps      <= 4'd0;
      r_ps_sel     <= 3'd0;
      r_ps_dir     <= 1'b0;
      r_ps_pulse   <= 1'b0;
`endif
    end else begin
      r_ps_ack <= 1'b0;
      r_ps_err <= 1'b0;
      case (r_state)
        RST_PLL: begin
          if (r_rst_cnt == RST_LAST) begin
            r_state     <= WAIT_LOCK;
            r_pll_reset <= 1'b0;
            r_rst_cnt   <= '0;
            r_tmo_cnt   <= '0;
          end else begin
            r_rst_cnt <= r_rst_cnt + RW'(1);
          end
        end

        WAIT_LOCK: begin
          if (r_tmo_cnt == TMO_LAST) begin
            r_state     <= RST_PLL;
            r_pll_reset <= 1'b1;
            r_rst_cnt   <= '0;
          end else begin
            r_tmo_cnt <= r_tmo_cnt + TW'(1);
            if (w_lock) begin
              r_state   <= STABLE;
              r_stb_cnt <= '0;
            end
          end
        end

        // Reaching the stable count wins over a coincident timeout
        STABLE: begin
          if (w_lock && (r_stb_cnt == STB_LAST)) begin
            r_state   <= READY;
            r_ready   <= 1'b1;
            r_mem_rst <= 1'b0;
          end else if (r_tmo_cnt == TMO_LAST) begin
            r_state     <= RST_PLL;
            r_pll_reset <= 1'b1;
            r_rst_cnt   <= '0;
          end else begin
            r_tmo_cnt <= r_tmo_cnt + TW'(1);
            if (!w_lock) begin
              r_state <= WAIT_LOCK;
            end else begin
              r_stb_cnt <= r_stb_cnt + SW'(1);
            end
          end
        end

        READY: begin
          if (!w_lock) begin
            r_state      <= RST_PLL;
            r_pll_reset  <= 1'b1;
            r_rst_cnt    <= '0;
            r_ready      <= 1'b0;
            r_mem_rst    <= 1'b1;
            r_relock_cnt <= sat_inc8(r_relock_cnt);
          end else if (ps_bus.ps_req) begin
`ifdef PLL_SEQ_PHASE_SHIFT_EN
            if (ps_bus.ps_steps == 4'd0) begin
              r_ps_ack <= 1'b1;
              r_ps_err <= 1'b0;
            end else begin
              // ps_pulse stays low this cycle so sel/dir lead the first rise
              r_ps_sel <= ps_bus.ps_ch;
              r_ps_dir <= ps_bus.ps_up;
              r_steps  <= ps_bus.ps_steps;
              r_ps_cnt <= '0;
              r_state  <= PS_PULSE;
            end
`else
            r_ps_ack <= 1'b1;
            r_ps_err <= 1'b1;
`endif
          end
        end

`ifdef PLL_SEQ_PHASE_SHIFT_EN
        PS_PULSE: begin
          if (!w_lock) begin
            r_ps_pulse   <= 1'b0;
            r_ps_ack     <= 1'b1;
            r_ps_err     <= 1'b1;
            r_state      <= RST_PLL;
            r_pll_reset  <= 1'b1;
            r_rst_cnt    <= '0;
            r_ready      <= 1'b0;
            r_mem_rst    <= 1'b1;
            r_relock_cnt <= sat_inc8(r_relock_cnt);
          end else if (!r_ps_pulse) begin
            r_ps_pulse <= 1'b1;
            r_ps_cnt   <= '0;
          end else if (r_ps_cnt == PUL_LAST) begin
            r_ps_pulse <= 1'b0;
            r_ps_cnt   <= '0;
            r_state    <= PS_SETTLE;
          end else begin
            r_ps_cnt <= r_ps_cnt + PW'(1);
          end
        end

        PS_SETTLE: begin
          if (!w_lock) begin
            r_ps_pulse   <= 1'b0;
            r_ps_ack     <= 1'b1;
            r_ps_err     <= 1'b1;
            r_state      <= RST_PLL;
            r_pll_reset  <= 1'b1;
            r_rst_cnt    <= '0;
            r_ready      <= 1'b0;
            r_mem_rst    <= 1'b1;
            r_relock_cnt <= sat_inc8(r_relock_cnt);
          end else if (r_ps_cnt == SET_LAST) begin
            r_ps_cnt <= '0;
            if (r_steps == 4'd1) begin
              r_steps  <= 4'd0;
              r_ps_ack <= 1'b1;
              r_ps_err <= 1'b0;
              r_state  <= READY;
            end else begin
              r_steps    <= r_steps - 4'd1;
              r_ps_pulse <= 1'b1;
              r_state    <= PS_PULSE;
            end
          end else begin
            r_ps_cnt <= r_ps_cnt + PW'(1);
          end
        end
`endif

        default: begin
          r_state     <= RST_PLL;
          r_pll_reset <= 1'b1;
          r_rst_cnt   <= '0;
          r_ready     <= 1'b0;
          r_mem_rst   <= 1'b1;
        end
      endcase
    end
  end

  assign o_pll_reset   = r_pll_reset;
  assign o_ready       = r_ready;
  assign o_mem_rst     = r_mem_rst;
  assign o_relock_cnt  = r_relock_cnt;
  assign ps_bus.ps_ack = r_ps_ack;
  assign ps_bus.ps_err = r_ps_err;

`ifdef PLL_SEQ_PHASE_SHIFT_EN
  assign o_ps_sel   = r_ps_sel;
  assign o_ps_dir   = r_ps_dir;
  assign o_ps_pulse = r_ps_pulse;
`else
  logic          w_unused_req;
  logic [PW-1:0] w_unused_ps;

  assign o_ps_sel     = 3'd0;
  assign o_ps_dir     = 1'b0;
  assign o_ps_pulse   = 1'b0;
  // Request fields are only consumed by the phase-step build
  assign w_unused_req = ^{ps_bus.ps_ch, ps_bus.ps_up, ps_bus.ps_steps};
  assign w_unused_ps  = PUL_LAST ^ SET_LAST;
`endif

endmodule

// File: tb/tb_pll_sequencer.sv
// Self-checking bench for pll_sequencer: cycle table for lock/relock, scoreboard for phase-step acks.
module tb_pll_sequencer;
  localparam int RP  = 4;
  localparam int LS  = 8;
  localparam int LT  = 64;
  localparam int PP  = 2;
  localparam int PSC = 3;

  typedef struct {
    int       cyc;
    logic     lock;
    logic     exp_rst;
    logic     exp_rdy;
    logic     exp_mrst;
    int       exp_relock;
  } vec_t;

  typedef struct {
    logic [2:0] ch;
    logic       up;
    logic [3:0] steps;
  } req_t;

  typedef struct {
    int         due;
    logic       err;
    int         pulses;
    logic [2:0] ch;
    logic       up;
  } exp_t;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       lock = 1'b1;
  logic       pll_reset;
  logic [2:0] ps_sel;
  logic       ps_dir;
  logic       ps_pulse;
  logic       ready;
  logic       mem_rst;
  logic [7:0] relock_cnt;

  int   n_tests = 0;
  int   n_fail = 0;
  int   cyc = 0;
  int   n_ack = 0;
  int   rises = 0;
  int   hi_run = 0;
  int   hi_total = 0;
  int   last_fall = 0;
  logic prev_pulse = 1'b0;
  exp_t sb[$];

  pll_sequencer_if bus ();

  pll_sequencer #(
    .RESET_PULSE_CYCLES (RP),
    .LOCK_STABLE_CYCLES (LS),
    .LOCK_TIMEOUT_CYCLES(LT),
    .PS_PULSE_CYCLES    (PP),
    .PS_SETTLE_CYCLES   (PSC)
  ) dut (
    .clk         (clk),
    .rst         (rst),
    .i_pll_lock  (lock),
    .o_pll_reset (pll_reset),
    .o_ps_sel    (ps_sel),
    .o_ps_dir    (ps_dir),
    .o_ps_pulse  (ps_pulse),
    .o_ready     (ready),
    .o_mem_rst   (mem_rst),
    .o_relock_cnt(relock_cnt),
    .ps_bus      (bus)
  );

  always #10 clk = ~clk;

  task automatic check(input string nm, input int act, input int exp);
    n_tests++;
    if (act != exp) begin
      n_fail++;
      $display("FAIL %s: got %0d, expected %0d (cycle %0d)", nm, act, exp, cyc);
    end
  endtask

  task automatic step();
    @(negedge clk);
    #1;
  endtask

  task automatic wait_ready(input int budget);
    int k;
    k = 0;
    while (!ready && k < budget) begin
      step();
      k++;
    end
    check("wait_ready", int'(ready), 1);
  endtask

  task automatic wait_sb(input int budget);
    int k;
    k = 0;
    while (sb.size() != 0 && k < budget) begin
      step();
      k++;
    end
    check("scoreboard_drain", sb.size(), 0);
    sb.delete();
  endtask

  // Output monitor: pulse shape checks and scoreboard pops on ps_ack
  always @(negedge clk) begin
    exp_t e;
    cyc = cyc + 1;
    if (rst) begin
      rises      = 0;
      hi_run     = 0;
      prev_pulse = 1'b0;
    end else begin
      if (ps_pulse) begin
        hi_total++;
        hi_run++;
        if (!prev_pulse) begin
          rises++;
          if (rises > 1) check("ps_gap", cyc - last_fall, PSC);
          if (sb.size() != 0) begin
            check("ps_sel", int'(ps_sel), int'(sb[0].ch));
            check("ps_dir", int'(ps_dir), int'(sb[0].up));
          end
        end
      end else if (prev_pulse) begin
        check("ps_width", hi_run, PP);
        hi_run    = 0;
        last_fall = cyc;
      end
      prev_pulse = ps_pulse;
      if (bus.ps_ack) begin
        n_ack++;
        if (sb.size() == 0) begin
          n_tests++;
          n_fail++;
          $display("FAIL unexpected_ack: got ps_ack=1, expected 0 (cycle %0d)", cyc);
        end else begin
          e = sb.pop_front();
          check("ack_cycle", cyc, e.due);
          check("ack_err", int'(bus.ps_err), int'(e.err));
          check("ack_pulses", rises, e.pulses);
        end
        rises = 0;
      end
    end
  end

  initial begin
    vec_t vecs[13];
    req_t reqs[3];
    exp_t e;
    int   t0;
    int   c;
    int   ack0;
    int   r1;
    int   r2;
    int   nr;
    int   w0;
    logic prev_rst;
    logic rdy_seen;

    // cyc lock pll_reset ready mem_rst relock (lock applied after the compare)
    vecs[0]  = '{0,  1'b1, 1'b1, 1'b0, 1'b1, 0};
    vecs[1]  = '{3,  1'b1, 1'b1, 1'b0, 1'b1, 0};
    vecs[2]  = '{4,  1'b1, 1'b0, 1'b0, 1'b1, 0};
    vecs[3]  = '{12, 1'b1, 1'b0, 1'b0, 1'b1, 0};
    vecs[4]  = '{13, 1'b1, 1'b0, 1'b1, 1'b0, 0};
    vecs[5]  = '{20, 1'b0, 1'b0, 1'b1, 1'b0, 0};
    vecs[6]  = '{21, 1'b1, 1'b0, 1'b1, 1'b0, 0};
    vecs[7]  = '{22, 1'b1, 1'b0, 1'b1, 1'b0, 0};
    vecs[8]  = '{23, 1'b1, 1'b1, 1'b0, 1'b1, 1};
    vecs[9]  = '{26, 1'b1, 1'b1, 1'b0, 1'b1, 1};
    vecs[10] = '{27, 1'b1, 1'b0, 1'b0, 1'b1, 1};
    vecs[11] = '{35, 1'b1, 1'b0, 1'b0, 1'b1, 1};
    vecs[12] = '{36, 1'b1, 1'b0, 1'b1, 1'b0, 1};

    reqs[0] = '{3'd2, 1'b1, 4'd3};
    reqs[1] = '{3'd5, 1'b0, 4'd0};
    reqs[2] = '{3'd7, 1'b0, 4'd1};

    bus.ps_req   = 1'b0;
    bus.ps_ch    = 3'd0;
    bus.ps_up    = 1'b0;
    bus.ps_steps = 4'd0;
    repeat (3) step();

    check("rst_pll_reset", int'(pll_reset), 1);
    check("rst_ready", int'(ready), 0);
    check("rst_mem_rst", int'(mem_rst), 1);
    check("rst_ps_pulse", int'(ps_pulse), 0);
    check("rst_ps_sel", int'(ps_sel), 0);
    check("rst_ps_dir", int'(ps_dir), 0);
    check("rst_ps_ack", int'(bus.ps_ack), 0);
    check("rst_ps_err", int'(bus.ps_err), 0);
    check("rst_relock", int'(relock_cnt), 0);

    rst = 1'b0;
    t0  = cyc;
    for (int i = 0; i < 13; i++) begin
      while (cyc - t0 < vecs[i].cyc) step();
      check($sformatf("vec%0d_pll_reset", i), int'(pll_reset), int'(vecs[i].exp_rst));
      check($sformatf("vec%0d_ready", i), int'(ready), int'(vecs[i].exp_rdy));
      check($sformatf("vec%0d_mem_rst", i), int'(mem_rst), int'(vecs[i].exp_mrst));
      check($sformatf("vec%0d_relock", i), int'(relock_cnt), vecs[i].exp_relock);
      lock = vecs[i].lock;
    end

    for (int i = 0; i < 3; i++) begin
      wait_ready(200);
      step();
      bus.ps_req   = 1'b1;
      bus.ps_ch    = reqs[i].ch;
      bus.ps_up    = reqs[i].up;
      bus.ps_steps = reqs[i].steps;
      e.ch = reqs[i].ch;
      e.up = reqs[i].up;
`ifdef PLL_SEQ_PHASE_SHIFT_EN
      e.err    = 1'b0;
      e.pulses = int'(reqs[i].steps);
      e.due    = (reqs[i].steps == 4'd0) ? cyc + 1 : cyc + 2 + (PP + PSC) * int'(reqs[i].steps);
`else
      e.err    = 1'b1;
      e.pulses = 0;
      e.due    = cyc + 1;
`endif
      sb.push_back(e);
      step();
      bus.ps_req = 1'b0;
      wait_sb(100);
    end

`ifdef PLL_SEQ_PHASE_SHIFT_EN
    // Lock lost during the second step of a 5-step request
    wait_ready(200);
    step();
    bus.ps_req   = 1'b1;
    bus.ps_ch    = 3'd3;
    bus.ps_up    = 1'b0;
    bus.ps_steps = 4'd5;
    c = cyc;
    sb.push_back('{c + 9, 1'b1, 2, 3'd3, 1'b0});
    step();
    bus.ps_req = 1'b0;
    while (cyc < c + 6) step();
    lock = 1'b0;
    wait_sb(50);
    check("abort_relock", int'(relock_cnt), 2);
    check("abort_pulse", int'(ps_pulse), 0);
    lock = 1'b1;
    wait_ready(300);

    // Reset in the middle of a step: pulse drops at once, no ack
    step();
    bus.ps_req   = 1'b1;
    bus.ps_ch    = 3'd1;
    bus.ps_up    = 1'b1;
    bus.ps_steps = 4'd4;
    c = cyc;
    step();
    bus.ps_req = 1'b0;
    while (cyc < c + 3) step();
    check("midstep_pulse_high", int'(ps_pulse), 1);
    ack0 = n_ack;
    rst  = 1'b1;
    #1;
    check("midstep_pulse_drop", int'(ps_pulse), 0);
    repeat (4) step();
    check("midstep_no_ack", n_ack, ack0);
`endif

    // Lock held low: periodic retries, never ready, requests ignored
    lock = 1'b0;
    rst  = 1'b1;
    repeat (3) step();
    ack0     = n_ack;
    rst      = 1'b0;
    t0       = cyc;
    prev_rst = 1'b1;
    rdy_seen = 1'b0;
    nr = 0;
    r1 = 0;
    r2 = 0;
    w0 = 1;
    for (int k = 1; k <= 150; k++) begin
      step();
      if (k == 10) begin
        bus.ps_req   = 1'b1;
        bus.ps_steps = 4'd2;
      end
      if (k == 11) bus.ps_req = 1'b0;
      if (pll_reset && !prev_rst) begin
        if (nr == 0) r1 = cyc - t0;
        if (nr == 1) r2 = cyc - t0;
        nr++;
      end
      if (pll_reset && nr == 0) w0++;
      if (ready) rdy_seen = 1'b1;
      prev_rst = pll_reset;
    end
    check("retry_first_width", w0, RP);
    check("retry_first_rise", r1, RP + LT);
    check("retry_period", r2 - r1, RP + LT);
    check("retry_never_ready", int'(rdy_seen), 0);
    check("retry_relock", int'(relock_cnt), 0);
    check("retry_req_ignored", n_ack, ack0);

`ifndef PLL_SEQ_PHASE_SHIFT_EN
    check("ps_pulse_never", hi_total, 0);
`endif

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

// File: doc/pll_sequencer.md
PLL_SEQUENCER -- requirements
Module: pll_sequencer

Interface
REQ-001 SHALL have parameter RESET_PULSE_CYCLES, default 16, the number of cycles pll_reset is held high per attempt.
REQ-002 SHALL have parameter LOCK_STABLE_CYCLES, default 1024, the number of consecutive synced-lock-high cycles required before ready.
REQ-003 SHALL have parameter LOCK_TIMEOUT_CYCLES, default 65536, the cycles allowed from WAIT_LOCK entry to READY before a retry.
REQ-004 SHALL have parameters PS_PULSE_CYCLES (default 4) and PS_SETTLE_CYCLES (default 8), the high time and post-pulse gap of each phase step.
REQ-005 clk  in  1  free-running 50 MHz reference clock, same source as the PLL input.
REQ-006 rst  in  1  asynchronous, active-high reset.
REQ-007 pll_lock  in  1  PLL LOCK, asynchronous to clk.
REQ-008 pll_reset  out  1  drives PLL RESET.
REQ-009 ps_sel  out  3, ps_dir  out  1, ps_pulse  out  1  drive PLL PSSEL/PSDIR/PSPULSE.
REQ-010 ps_req  in  1, ps_ch  in  3, ps_up  in  1, ps_steps  in  4  phase-step request: channel, direction (1 = up), and step count.
REQ-011 ps_ack  out  1 (single-cycle completion strobe) and ps_err  out  1 (valid with ps_ack; 1 = aborted or rejected).
REQ-012 ready  out  1 (lock stable), mem_rst  out  1 (active-high memory-domain reset = ~ready), relock_cnt  out  8 (saturating lock-loss count).

Function
REQ-013 pll_lock SHALL pass through a 2-FF synchronizer; all decisions use the synced value (2-cycle latency).
REQ-014 The FSM SHALL have the states RST_PLL, WAIT_LOCK, STABLE, READY, PS_PULSE, and PS_SETTLE.
REQ-015 In RST_PLL, pll_reset SHALL be 1 for exactly RESET_PULSE_CYCLES cycles, after which the FSM goes to WAIT_LOCK and clears the timeout counter.
REQ-016 In WAIT_LOCK, synced lock = 1 SHALL cause a transition to STABLE with the stable counter cleared.
REQ-017 In STABLE, synced lock = 0 SHALL return the FSM to WAIT_LOCK without clearing the timeout counter; LOCK_STABLE_CYCLES consecutive highs SHALL lead to READY.
REQ-018 Timeout SHALL count in both WAIT_LOCK and STABLE; on reaching LOCK_TIMEOUT_CYCLES, the FSM SHALL go to RST_PLL (retry indefinitely).
REQ-019 In READY, ready SHALL be 1 and mem_rst SHALL be 0 on the same registered edge.
REQ-020 In READY, synced lock = 0 SHALL cause the next state to be RST_PLL, with ready cleared and relock_cnt incremented (saturating at 255).
REQ-021 In READY, ps_req = 1 with ps_steps != 0 SHALL latch ps_ch, ps_up, and ps_steps, then enter PS_PULSE; ps_req is ignored in all other states.
REQ-022 In READY, ps_req = 1 with ps_steps = 0 SHALL produce ps_ack = 1 and ps_err = 0 on the next cycle, with no pulse.
REQ-023 In PS_PULSE, ps_pulse SHALL be 1 for PS_PULSE_CYCLES cycles, followed by PS_SETTLE with ps_pulse = 0 for PS_SETTLE_CYCLES cycles.
REQ-024 After PS_SETTLE, the remaining step count SHALL decrement; if it is nonzero the FSM returns to PS_PULSE, and if it is zero the block asserts ps_ack = 1, ps_err = 0 and returns to READY.
REQ-025 ps_sel and ps_dir SHALL hold their latched values throughout a request and SHALL be stable at least 1 cycle before the first ps_pulse rise.
REQ-026 Synced lock = 0 during PS_PULSE or PS_SETTLE SHALL abort the request: ps_pulse = 0, ps_ack = 1, ps_err = 1, next state RST_PLL, and relock_cnt incremented.
REQ-027 ready SHALL remain 1 during PS_PULSE and PS_SETTLE.
REQ-028 All counters SHALL be sized to $clog2 of their parameter plus 1 and SHALL NOT wrap.

Reset
REQ-029 rst SHALL asynchronously force: state RST_PLL with counter 0, pll_reset = 1, ready = 0, mem_rst = 1, ps_pulse = 0, ps_sel = 0, ps_dir = 0, ps_ack = 0, ps_err = 0, relock_cnt = 0, and synchronizer flops = 0.
REQ-030 rst asserted mid-phase-step SHALL drop ps_pulse immediately and SHALL NOT produce ps_ack.

Configuration
REQ-031 With macro PLL_SEQ_PHASE_SHIFT_EN defined, the phase-step logic (REQ-021 to REQ-026) SHALL be compiled in.
REQ-032 Without PLL_SEQ_PHASE_SHIFT_EN: ps_sel, ps_dir, and ps_pulse SHALL be tied to 0; PS states SHALL be absent; and any ps_req in READY SHALL produce ps_ack = 1, ps_err = 1 on the next cycle.

Verification (bench parameters: RESET_PULSE_CYCLES=4, LOCK_STABLE_CYCLES=8, LOCK_TIMEOUT_CYCLES=64, PS_PULSE_CYCLES=2, PS_SETTLE_CYCLES=3)
REQ-033 Release rst with pll_lock = 1 from cycle 0 -> pll_reset high for 4 cycles, ready rises 4 + 2 + 8 (±1) cycles later, and mem_rst falls on the same edge.
REQ-034 Hold pll_lock = 0 -> pll_reset re-pulses every 4 + 64 cycles, ready stays 0, and relock_cnt stays 0.
REQ-035 In READY, drop pll_lock for 1 cycle -> ready falls 3 cycles later, pll_reset pulses, relock_cnt = 1, and ready returns after re-lock.
REQ-036 Request ps_req with ps_ch = 2, ps_up = 1, ps_steps = 3 -> three ps_pulse highs of 2 cycles with 3-cycle gaps, ps_sel = 2 and ps_dir = 1 throughout, then ps_ack = 1 with ps_err = 0.
REQ-037 Drop pll_lock during the second step of a 5-step request -> ps_ack = 1, ps_err = 1, ps_pulse = 0, and relock_cnt incremented.
REQ-038 With the macro undefined, a ps_req in READY -> ps_ack = 1 and ps_err = 1 one cycle later, and ps_pulse is never 1.
